// File: rtl/fp_result_stage_pkg.sv
// Shared IEEE-754 class/exception bit layout and skid-buffer state encoding
// for the adder result stage.
package fp_result_stage_pkg;

  // Result class one-hot bit positions
  localparam int NTYPES    = 6;
  localparam int SNAN      = 0;
  localparam int QNAN      = 1;
  localparam int INF       = 2;
  localparam int ZERO      = 3;
  localparam int NORMAL    = 4;
  localparam int SUBNORMAL = 5;

  // Exception bit positions
  localparam int NEXCEPTIONS = 5;
  localparam int INVALID     = 0;
  localparam int DIVBYZERO   = 1;
  localparam int OVERFLOW    = 2;
  localparam int UNDERFLOW   = 3;
  localparam int INEXACT     = 4;

  localparam logic [15:0] BEAT_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == BEAT_CNT_MAX) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/fp_skid_buf.sv
// Two-entry skid buffer: registered output slot plus one skid slot, with a
// registered ready so upstream never sees a combinational path from out_ready.
module fp_skid_buf
  import fp_result_stage_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e state_q, state_d;
  logic         ready_q;
  logic [W-1:0] out_q;
  logic [W-1:0] skid_q;
  logic         accept;
  logic         emit;
  logic         load_out_in;
  logic         load_out_skid;
  logic         load_skid;

  assign accept    = in_valid & ready_q;
  assign emit      = (state_q != EMPTY) & out_ready;
  assign in_ready  = ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = out_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d       = state_q;
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          load_out_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && emit) begin
          load_out_in = 1'b1;
        end else if (accept) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (emit) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // ready_q is low here, so only the drain path exists
        if (emit) begin
          state_d       = ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != FULL);
      if (load_out_in) begin
        out_q <= in_data;
      end else if (load_out_skid) begin
        out_q <= skid_q;
      end
    end
  end

  // NOTE: the skid slot is not reset; it is only ever read after being written.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_q <= in_data;
    end
  end

endmodule

// File: rtl/fp_result_stage.sv
// Registered result stage behind the FP adder: skid-buffered payload, sticky
// exception status and a saturating beat counter. Optional trap: FP_RESULT_TRAP_EN.
module fp_result_stage
  import fp_result_stage_pkg::*;
#(
  parameter int NEXP = 5,
  parameter int NSIG = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NEXP+NSIG:0]     in_s,
  input  logic [NTYPES-1:0]      in_flags,
  input  logic [NEXCEPTIONS-1:0] in_exc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NEXP+NSIG:0]     out_s,
  output logic [NTYPES-1:0]      out_flags,
  output logic [NEXCEPTIONS-1:0] out_exc,
  input  logic                   clear_sticky,
  output logic [NEXCEPTIONS-1:0] sticky_exc,
  output logic [15:0]            beat_cnt
`ifdef FP_RESULT_TRAP_EN
  ,
  input  logic [NEXCEPTIONS-1:0] trap_mask,
  output logic                   trap
`endif
);

  localparam int NS = NEXP + NSIG + 1;
  localparam int PW = NS + NTYPES + NEXCEPTIONS;

  logic                   buf_ready;
  logic                   buf_in_valid;
  logic                   accept;
  logic [PW-1:0]          buf_out;
  logic [NEXCEPTIONS-1:0] sticky_q;
  logic [15:0]            cnt_q;

`ifdef FP_RESULT_TRAP_EN
  logic trap_q;

  // Both terms are flops, so in_ready still has no combinational input path
  assign in_ready     = buf_ready & ~trap_q;
  assign buf_in_valid = in_valid & ~trap_q;
  assign trap         = trap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      trap_q <= 1'b0;
    end else if (accept && ((in_exc & trap_mask) != '0)) begin
      trap_q <= 1'b1;
    end else if (clear_sticky) begin
      trap_q <= 1'b0;
    end
  end
`else
  assign in_ready     = buf_ready;
  assign buf_in_valid = in_valid;
`endif

  assign accept = in_valid & in_ready;

  fp_skid_buf #(
    .W(PW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_valid (buf_in_valid),
    .in_ready (buf_ready),
    .in_data  ({in_s, in_flags, in_exc}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (buf_out)
  );

  assign {out_s, out_flags, out_exc} = buf_out;

  // A beat accepted alongside clear_sticky is the first beat of the new window
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
      cnt_q    <= '0;
    end else if (clear_sticky) begin
      sticky_q <= accept ? in_exc : '0;
      cnt_q    <= accept ? 16'd1 : 16'd0;
    end else if (accept) begin
      sticky_q <= sticky_q | in_exc;
      cnt_q    <= sat_inc16(cnt_q);
    end
  end

  assign sticky_exc = sticky_q;
  assign beat_cnt   = cnt_q;

endmodule

// File: tb/tb_fp_result_stage.sv
// Scoreboard bench for fp_result_stage (NEXP=5, NSIG=10); trap scenario
// is compiled in when FP_RESULT_TRAP_EN is defined.
module tb_fp_result_stage;
  import fp_result_stage_pkg::*;

  typedef struct packed {
    logic [15:0]            s;
    logic [NTYPES-1:0]      f;
    logic [NEXCEPTIONS-1:0] e;
  } beat_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [15:0]            in_s;
  logic [NTYPES-1:0]      in_flags;
  logic [NEXCEPTIONS-1:0] in_exc;
  logic                   out_valid;
  logic                   out_ready;
  logic [15:0]            out_s;
  logic [NTYPES-1:0]      out_flags;
  logic [NEXCEPTIONS-1:0] out_exc;
  logic                   clear_sticky;
  logic [NEXCEPTIONS-1:0] sticky_exc;
  logic [15:0]            beat_cnt;
`ifdef FP_RESULT_TRAP_EN
  logic [NEXCEPTIONS-1:0] trap_mask;
  logic                   trap;
`endif

  int total = 0;
  int bad   = 0;
  beat_t sb[$];

  always #5 clk = ~clk;

  fp_result_stage #(
    .NEXP(5),
    .NSIG(10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_s        (in_s),
    .in_flags    (in_flags),
    .in_exc      (in_exc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_s       (out_s),
    .out_flags   (out_flags),
    .out_exc     (out_exc),
    .clear_sticky(clear_sticky),
    .sticky_exc  (sticky_exc),
    .beat_cnt    (beat_cnt)
`ifdef FP_RESULT_TRAP_EN
    ,
    .trap_mask   (trap_mask),
    .trap        (trap)
`endif
  );

  // Inputs change 1 time unit after posedge, so the negedge sees what the next edge will sample
  always @(negedge clk) begin
    beat_t exp_b;
    beat_t got_b;
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        total++;
        got_b = {out_s, out_flags, out_exc};
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_underflow: emitted %h with no beat expected", got_b);
        end else begin
          exp_b = sb.pop_front();
          if (got_b !== exp_b) begin
            bad++;
            $display("FAIL sb_order: got s=%h f=%b e=%b want s=%h f=%b e=%b",
                     got_b.s, got_b.f, got_b.e, exp_b.s, exp_b.f, exp_b.e);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back({in_s, in_flags, in_exc});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] s, input logic [NTYPES-1:0] f,
                           input logic [NEXCEPTIONS-1:0] e, input logic clr);
    logic was_ready;
    bit   done;
    done         = 0;
    in_s         = s;
    in_flags     = f;
    in_exc       = e;
    in_valid     = 1'b1;
    clear_sticky = clr;
    for (int i = 0; i < 20 && !done; i++) begin
      was_ready = in_ready;
      tick();
      if (was_ready) done = 1;
    end
    in_valid     = 1'b0;
    clear_sticky = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL send_timeout: beat %h not accepted within 20 cycles", s);
    end
  endtask

  task automatic expect_val(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    do_reset();
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    if ({out_s, out_flags, out_exc} !== '0) begin
      bad++; $display("FAIL rst_payload: got %h want 0", {out_s, out_flags, out_exc});
    end
    if (sticky_exc !== '0) begin bad++; $display("FAIL rst_sticky: got %b want 0", sticky_exc); end
    if (beat_cnt !== 16'd0) begin bad++; $display("FAIL rst_cnt: got %h want 0", beat_cnt); end
    total += 5;
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    in_s      = 16'h3C00;
    in_flags  = NTYPES'(1) << NORMAL;
    in_exc    = '0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    expect_val("single_out_valid", 32'(out_valid), 32'd1);
    expect_val("single_out_s", 32'(out_s), 32'h3C00);
    expect_val("single_cnt", 32'(beat_cnt), 32'd1);
    tick();
    expect_val("single_drained", 32'(out_valid), 32'd0);
  endtask

  task automatic test_backpressure();
    logic was_ready;
    bit   done;
    do_reset();
    out_ready = 1'b0;
    in_flags  = NTYPES'(1) << NORMAL;
    in_exc    = '0;
    in_s      = 16'h3C00;
    in_valid  = 1'b1;
    tick();
    expect_val("bp_ready_one", 32'(in_ready), 32'd1);
    in_s = 16'h4000;
    tick();
    expect_val("bp_ready_full", 32'(in_ready), 32'd0);
    in_s = 16'h4200;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_val("bp_hold_ready", 32'(in_ready), 32'd0);
      expect_val("bp_hold_valid", 32'(out_valid), 32'd1);
      expect_val("bp_hold_s", 32'(out_s), 32'h3C00);
    end
    expect_val("bp_cnt_two", 32'(beat_cnt), 32'd2);
    out_ready = 1'b1;
    done      = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      was_ready = in_ready;
      tick();
      if (was_ready) done = 1;
    end
    in_valid = 1'b0;
    expect_val("bp_third_accepted", 32'(done), 32'd1);
    repeat (4) tick();
    expect_val("bp_cnt_three", 32'(beat_cnt), 32'd3);
    expect_val("bp_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic test_sticky();
    do_reset();
    out_ready = 1'b1;
    send_beat(16'h7C00, NTYPES'(1) << INF, NEXCEPTIONS'(1) << OVERFLOW, 1'b0);
    expect_val("sticky_no_block", 32'(in_ready), 32'd1);
    send_beat(16'h3C01, NTYPES'(1) << NORMAL, NEXCEPTIONS'(1) << INEXACT, 1'b0);
    expect_val("sticky_or", 32'(sticky_exc),
               32'((NEXCEPTIONS'(1) << OVERFLOW) | (NEXCEPTIONS'(1) << INEXACT)));
    expect_val("sticky_cnt2", 32'(beat_cnt), 32'd2);
    send_beat(16'h7E00, NTYPES'(1) << QNAN, NEXCEPTIONS'(1) << INVALID, 1'b1);
    expect_val("sticky_clear_acc", 32'(sticky_exc), 32'(NEXCEPTIONS'(1) << INVALID));
    expect_val("sticky_clear_cnt", 32'(beat_cnt), 32'd1);
    clear_sticky = 1'b1;
    tick();
    clear_sticky = 1'b0;
    expect_val("sticky_clear_only", 32'(sticky_exc), 32'd0);
    expect_val("sticky_clear_cnt0", 32'(beat_cnt), 32'd0);
    repeat (2) tick();
  endtask

  task automatic test_reset_full();
    do_reset();
    out_ready = 1'b0;
    send_beat(16'h4400, NTYPES'(1) << NORMAL, NEXCEPTIONS'(1) << OVERFLOW, 1'b0);
    send_beat(16'h4500, NTYPES'(1) << NORMAL, NEXCEPTIONS'(1) << UNDERFLOW, 1'b0);
    expect_val("rf_full_ready", 32'(in_ready), 32'd0);
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    expect_val("rf_out_valid", 32'(out_valid), 32'd0);
    expect_val("rf_sticky", 32'(sticky_exc), 32'd0);
    expect_val("rf_cnt", 32'(beat_cnt), 32'd0);
    expect_val("rf_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_val("rf_no_stale", 32'(out_valid), 32'd0);
    end
  endtask

`ifdef FP_RESULT_TRAP_EN
  task automatic test_trap();
    do_reset();
    out_ready = 1'b1;
    trap_mask = NEXCEPTIONS'(1) << INVALID;
    send_beat(16'h7E00, NTYPES'(1) << QNAN, NEXCEPTIONS'(1) << INVALID, 1'b0);
    expect_val("trap_set", 32'(trap), 32'd1);
    expect_val("trap_block", 32'(in_ready), 32'd0);
    in_s     = 16'h3C00;
    in_flags = NTYPES'(1) << NORMAL;
    in_exc   = '0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_val("trap_hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    expect_val("trap_cnt_held", 32'(beat_cnt), 32'd1);
    clear_sticky = 1'b1;
    tick();
    clear_sticky = 1'b0;
    expect_val("trap_cleared", 32'(trap), 32'd0);
    expect_val("trap_resume", 32'(in_ready), 32'd1);
    send_beat(16'h3C00, NTYPES'(1) << NORMAL, '0, 1'b0);
    expect_val("trap_after_cnt", 32'(beat_cnt), 32'd1);
    trap_mask = '0;
    repeat (2) tick();
  endtask
`endif

  task automatic test_back_to_back_saturate();
    logic was_ready;
    int   n;
    int   cycles;
    do_reset();
    out_ready = 1'b1;
    in_s      = 16'h3800;
    in_flags  = NTYPES'(1) << NORMAL;
    in_exc    = '0;
    in_valid  = 1'b1;
    n         = 0;
    cycles    = 0;
    while (n < 65537 && cycles < 70000) begin
      was_ready = in_ready;
      tick();
      cycles++;
      if (was_ready) n++;
    end
    in_valid = 1'b0;
    expect_val("sat_accepted", 32'(n), 32'd65537);
    expect_val("sat_one_per_cycle", 32'(cycles), 32'd65537);
    expect_val("sat_cnt", 32'(beat_cnt), 32'hFFFF);
    repeat (3) tick();
    expect_val("sat_sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_s         = '0;
    in_flags     = '0;
    in_exc       = '0;
    out_ready    = 1'b0;
    clear_sticky = 1'b0;
`ifdef FP_RESULT_TRAP_EN
    trap_mask = '0;
`endif
    test_reset();
    test_single();
    test_backpressure();
    test_sticky();
    test_reset_full();
`ifdef FP_RESULT_TRAP_EN
    test_trap();
`endif
    test_back_to_back_saturate();
    expect_val("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
